// File: rtl/vec_pipe_core.sv
// vec_pipe_core: 5-stage R-lane vector pipeline (IF/ID, ID, EX, MEM, WB) with forwarding and load-use stall.
// Optional VEC_SAT_EN: unsigned saturating ADD/ADDI/SUB; undefined gives modulo-2^N wrap-around.

module vec_pipe_core_lane #(
  parameter int N = 8
) (
  input  logic [3:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [7:0]   imm_i,
  output logic [N-1:0] res_o,
  output logic         carry_o,
  output logic         zero_o
);
  logic [N-1:0] opb;
  logic [N:0]   sum, diff;

  always_comb begin
    opb     = (op_i == 4'h8) ? N'(imm_i) : b_i;
    sum     = {1'b0, a_i} + {1'b0, opb};
    diff    = {1'b0, a_i} - {1'b0, opb};
    res_o   = '0;
    carry_o = 1'b0;
    case (op_i)
      4'h1, 4'h8: begin
        carry_o = sum[N];
`ifdef VEC_SAT_EN
        res_o   = sum[N] ? '1 : sum[N-1:0];
`else
        res_o   = sum[N-1:0];
`endif
      end
      4'h2: begin
        carry_o = diff[N];
`ifdef VEC_SAT_EN
        res_o   = diff[N] ? '0 : diff[N-1:0];
`else
        res_o   = diff[N-1:0];
`endif
      end
      4'h3:    res_o = a_i & b_i;
      4'h4:    res_o = a_i | b_i;
      4'h5:    res_o = a_i ^ b_i;
      4'h6:    res_o = a_i << b_i[2:0];
      4'h7:    res_o = a_i >> b_i[2:0];
      default: res_o = '0;
    endcase
    zero_o = (res_o == '0);
  end
endmodule

module vec_pipe_core #(
  parameter int I  = 32,
  parameter int N  = 8,
  parameter int R  = 6,
  parameter int AW = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [I-1:0]   InstrF,
  output logic           StallF,
  output logic           MemWriteM,
  output logic           MemReadM,
  output logic [AW-1:0]  AddressM,
  output logic [R*N-1:0] WriteDataM,
  input  logic [R*N-1:0] ReadData,
  output logic           FlagsWriteW,
  output logic [R*2-1:0] ALUFlagsW
);
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDV  = 4'h9;
  localparam logic [3:0] OP_STV  = 4'hA;

  typedef struct packed {
    logic [3:0]     op;
    logic [3:0]     rd;
    logic [3:0]     ra;
    logic [3:0]     rp2;
    logic [7:0]     imm;
    logic           rwe;
    logic           mrd;
    logic           mwr;
    logic           fwe;
    logic [R*N-1:0] a;
    logic [R*N-1:0] b;
  } idex_t;

  typedef struct packed {
    logic           rwe;
    logic           mrd;
    logic           mwr;
    logic           fwe;
    logic [3:0]     rd;
    logic [R*N-1:0] res;
    logic [2*R-1:0] flg;
    logic [AW-1:0]  addr;
    logic [R*N-1:0] wdat;
  } exmem_t;

  typedef struct packed {
    logic           rwe;
    logic           fwe;
    logic [3:0]     rd;
    logic [R*N-1:0] res;
    logic [2*R-1:0] flg;
  } memwb_t;

  logic [I-1:0]          ifid_q;
  idex_t                 idex_d, idex_q;
  exmem_t                exmem_d, exmem_q;
  memwb_t                memwb_d, memwb_q;
  logic [15:0][R*N-1:0]  rf_q;

  logic [3:0] id_op, id_rd, id_ra, id_rb, id_p2;
  logic [7:0] id_imm;
  logic       id_use_a, id_use_b, stall;
  logic       unused_ifid;

  assign unused_ifid = ^{ifid_q[27:25], ifid_q[8:0]};

  // ID: decode, register read with write-through from WB, load-use detection
  always_comb begin
    id_op    = (ifid_q[31:28] > OP_STV) ? OP_NOP : ifid_q[31:28];
    id_rd    = ifid_q[24:21];
    id_ra    = ifid_q[20:17];
    id_rb    = ifid_q[16:13];
    id_imm   = ifid_q[16:9];
    id_p2    = (id_op == OP_STV) ? id_rd : id_rb;
    id_use_a = (id_op != OP_NOP);
    id_use_b = (id_op != OP_NOP) && (id_op != OP_ADDI) && (id_op != OP_LDV);
    stall    = idex_q.mrd && ((id_use_a && (id_ra == idex_q.rd)) ||
                              (id_use_b && (id_p2 == idex_q.rd)));
    idex_d   = '0;
    if (!stall) begin
      idex_d.op  = id_op;
      idex_d.rd  = id_rd;
      idex_d.ra  = id_ra;
      idex_d.rp2 = id_p2;
      idex_d.imm = id_imm;
      idex_d.rwe = (id_op != OP_NOP) && (id_op != OP_STV);
      idex_d.fwe = (id_op != OP_NOP) && (id_op <= OP_ADDI);
      idex_d.mrd = (id_op == OP_LDV);
      idex_d.mwr = (id_op == OP_STV);
      idex_d.a   = (memwb_q.rwe && (memwb_q.rd == id_ra)) ? memwb_q.res : rf_q[id_ra];
      idex_d.b   = (memwb_q.rwe && (memwb_q.rd == id_p2)) ? memwb_q.res : rf_q[id_p2];
    end
  end

  assign StallF = stall;

  // EX: a load sitting in MEM has no data yet, so it is never a forward source
  logic [R*N-1:0]        fwd_a, fwd_b;
  logic [R-1:0][N-1:0]   ex_a, ex_b, ex_res;
  logic [2*R-1:0]        ex_flg;
  logic [AW-1:0]         ex_addr;

  always_comb begin
    fwd_a = idex_q.a;
    if (exmem_q.rwe && !exmem_q.mrd && (exmem_q.rd == idex_q.ra))
      fwd_a = exmem_q.res;
    else if (memwb_q.rwe && (memwb_q.rd == idex_q.ra))
      fwd_a = memwb_q.res;
    fwd_b = idex_q.b;
    if (exmem_q.rwe && !exmem_q.mrd && (exmem_q.rd == idex_q.rp2))
      fwd_b = exmem_q.res;
    else if (memwb_q.rwe && (memwb_q.rd == idex_q.rp2))
      fwd_b = memwb_q.res;
  end

  assign ex_a = fwd_a;
  assign ex_b = fwd_b;

  for (genvar g = 0; g < R; g++) begin : g_lane
    vec_pipe_core_lane #(.N(N)) u_lane (
      .op_i    (idex_q.op),
      .a_i     (ex_a[g]),
      .b_i     (ex_b[g]),
      .imm_i   (idex_q.imm),
      .res_o   (ex_res[g]),
      .carry_o (ex_flg[2*g+1]),
      .zero_o  (ex_flg[2*g])
    );
  end

  assign ex_addr = {ex_a[3], ex_a[2], ex_a[1], ex_a[0]} + AW'(idex_q.imm);

  always_comb begin
    exmem_d      = '0;
    exmem_d.rwe  = idex_q.rwe;
    exmem_d.mrd  = idex_q.mrd;
    exmem_d.mwr  = idex_q.mwr;
    exmem_d.fwe  = idex_q.fwe;
    exmem_d.rd   = idex_q.rd;
    exmem_d.res  = ex_res;
    exmem_d.flg  = idex_q.fwe ? ex_flg : '0;
    exmem_d.addr = ex_addr;
    exmem_d.wdat = fwd_b;
  end

  // MEM: load data is captured at the end of this stage
  always_comb begin
    memwb_d     = '0;
    memwb_d.rwe = exmem_q.rwe;
    memwb_d.fwe = exmem_q.fwe;
    memwb_d.rd  = exmem_q.rd;
    memwb_d.res = exmem_q.mrd ? ReadData : exmem_q.res;
    memwb_d.flg = exmem_q.flg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      rf_q    <= '0;
    end else begin
      if (!stall) ifid_q <= InstrF;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      if (memwb_q.rwe) rf_q[memwb_q.rd] <= memwb_q.res;
    end
  end

  assign MemWriteM   = exmem_q.mwr;
  assign MemReadM    = exmem_q.mrd;
  assign AddressM    = exmem_q.addr;
  assign WriteDataM  = exmem_q.wdat;
  assign FlagsWriteW = memwb_q.fwe;
  assign ALUFlagsW   = memwb_q.flg;
endmodule
